counter_sweep_ctrl: RTL and testbench

//  Sequencer for the up/down counter (count, clk, reset, en, u_d). Clears the counter, seeks
//  to a lower limit, then runs N triangle sweeps lo->hi->lo by driving en/u_d from the counter's

---
 rtl/counter_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: clear, seek to lo, then n sweeps lo->hi->lo.
// Optional endpoint dwell states are compiled in with `define COUNTER_SWEEP_DWELL_EN.
module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
`ifdef COUNTER_SWEEP_DWELL_EN
   ,parameter int DWELL   = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0]   count,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic               cnt_clr_n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SEEK     = 3'd2;
    localparam logic [2:0] S_UP       = 3'd3;
    localparam logic [2:0] S_DN       = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
`ifdef COUNTER_SWEEP_DWELL_EN
    localparam logic [2:0] S_DWELL_HI = 3'd6;
    localparam logic [2:0] S_DWELL_LO = 3'd7;
    localparam int         TMR_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DWELL - 1);

    logic [TMR_W-1:0] tmr, tmr_d;
`endif

    logic [2:0]         state, state_d;
    logic [WIDTH-1:0]   lo_q, hi_q, lo_d, hi_d;
    logic [SWEEP_W-1:0] n_q, n_d, sweep_d;
    logic               err_d;

    always_comb begin
        state_d = state;
        lo_d    = lo_q;
        hi_d    = hi_q;
        n_d     = n_q;
        sweep_d = sweep_cnt;
        err_d   = 1'b0;
`ifdef COUNTER_SWEEP_DWELL_EN
        tmr_d   = tmr;
`endif
        if (abort) begin
            state_d = S_IDLE;
        end else if (!hold) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((lo > hi) || (n_sweeps == '0)) begin
                            err_d = 1'b1;
                        end else begin
                            lo_d    = lo;
                            hi_d    = hi;
                            n_d     = n_sweeps;
                            sweep_d = '0;
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_CLEAR: state_d = S_SEEK;
                S_SEEK:  if (count == lo_q) state_d = S_UP;
                S_UP: begin
                    if (count == hi_q) begin
`ifdef COUNTER_SWEEP_DWELL_EN
                        state_d = S_DWELL_HI;
                        tmr_d   = TMR_LOAD;
`else
                        state_d = S_DN;
`endif
                    end
                end
                S_DN: begin
                    // the compare-true cycle is the stall; the sweep is credited on leaving it
                    if (count == lo_q) begin
                        sweep_d = sweep_cnt + 1'b1;
`ifdef COUNTER_SWEEP_DWELL_EN
                        state_d = S_DWELL_LO;
                        tmr_d   = TMR_LOAD;
`else
                        state_d = (sweep_d == n_q) ? S_DONE : S_UP;
`endif
                    end
                end
`ifdef COUNTER_SWEEP_DWELL_EN
                S_DWELL_HI: begin
                    if (tmr == '0) state_d = S_DN;
                    else           tmr_d   = tmr - 1'b1;
                end
                S_DWELL_LO: begin
                    if (tmr == '0) state_d = (sweep_cnt == n_q) ? S_DONE : S_UP;
                    else           tmr_d   = tmr - 1'b1;
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            sweep_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef COUNTER_SWEEP_DWELL_EN
            tmr       <= '0;
`endif
        end else begin
            state     <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            n_q       <= n_d;
            sweep_cnt <= sweep_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE) && (state != S_DONE);
            err       <= err_d;
`ifdef COUNTER_SWEEP_DWELL_EN
            tmr       <= tmr_d;
`endif
        end
    end

    // counter controls follow the live count so the endpoint cycle never steps past a limit
    assign cnt_clr_n = (state != S_CLEAR);
    assign cnt_up    = (state != S_DN);

    always_comb begin
        cnt_en = 1'b0;
        if (!hold && !abort) begin
            case (state)
                S_SEEK:  cnt_en = (count != lo_q);
                S_UP:    cnt_en = (count != hi_q);
                S_DN:    cnt_en = (count != lo_q);
                default: cnt_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural up/down counter plant plus a per-cycle count timeline model.
module tb_counter_sweep_ctrl;

`ifdef COUNTER_SWEEP_DWELL_EN
    localparam int TB_DWELL = 3;
`else
    localparam int TB_DWELL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, hold;
    logic [3:0] lo, hi, count;
    logic [7:0] n_sweeps, sweep_cnt;
    logic       cnt_en, cnt_up, cnt_clr_n, busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    int exp_q[$];
    bit up_q[$];
    int sw_end[$];

    always #5 clk = ~clk;

    counter_sweep_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .lo(lo), .hi(hi), .n_sweeps(n_sweeps), .count(count),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr_n(cnt_clr_n),
        .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
    );

    // the counter being sequenced; its reset is shared with the controller's reset net
    logic ctr_rst_n;
    assign ctr_rst_n = reset & cnt_clr_n;
    always_ff @(posedge clk or negedge ctr_rst_n) begin
        if (!ctr_rst_n)  count <= 4'd0;
        else if (cnt_en) count <= cnt_up ? count + 4'd1 : count - 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected count after each edge following the accepted start
    task automatic build(input int lo_v, input int hi_v, input int n_v);
        exp_q.delete(); up_q.delete(); sw_end.delete();
        exp_q.push_back(0); up_q.push_back(1'b1);
        for (int v = 0; v <= lo_v; v++) begin exp_q.push_back(v); up_q.push_back(1'b1); end
        for (int s = 0; s < n_v; s++) begin
            for (int v = lo_v; v <= hi_v; v++) begin exp_q.push_back(v); up_q.push_back(1'b1); end
            repeat (TB_DWELL) begin exp_q.push_back(hi_v); up_q.push_back(1'b1); end
            for (int v = hi_v; v >= lo_v; v--) begin exp_q.push_back(v); up_q.push_back(1'b0); end
            sw_end.push_back(exp_q.size() - 1);
            repeat (TB_DWELL) begin exp_q.push_back(lo_v); up_q.push_back(1'b1); end
        end
    endtask

    // poke_at = -2 pulses an (invalid) start during the done cycle
    task automatic do_run(input int lo_v, input int hi_v, input int n_v, input int hold_at,
                          input int hold_len, input int abort_at, input int poke_at,
                          output int done_t);
        int  k, held, len, nsw, pk;
        bit  h, ab, en_exp;
        build(lo_v, hi_v, n_v);
        len    = exp_q.size();
        pk     = (poke_at == -2) ? len : poke_at;
        done_t = -1;
        start = 1'b1; lo = lo_v[3:0]; hi = hi_v[3:0]; n_sweeps = n_v[7:0];
        tick();
        start = 1'b0;
        k = 0; held = 0;
        for (int t = 0; t < 4000; t++) begin
            h  = (k == hold_at) && (held < hold_len);
            ab = (k == abort_at);
            hold = h; abort = ab;
            start = (k == pk);
            if (start) begin lo = 4'd15; hi = 4'd0; n_sweeps = 8'd0; end
            #1;
            nsw = 0;
            foreach (sw_end[j]) if (sw_end[j] < k) nsw++;
            chk("sweep_cnt", sweep_cnt, nsw);
            chk("err_quiet", err, 0);
            if (k < len) begin
                en_exp = !h && !ab && (k + 1 < len) && (exp_q[k+1] != exp_q[k]);
                chk("count", count, exp_q[k]);
                chk("cnt_en", cnt_en, en_exp);
                chk("cnt_up", cnt_up, up_q[k]);
                chk("cnt_clr_n", cnt_clr_n, (k != 0));
                chk("busy_run", busy, 1);
                chk("done_early", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_done", busy, 1);
                chk("cnt_en_done", cnt_en, 0);
                done_t = t;
            end
            tick();
            hold = 1'b0; abort = 1'b0; start = 1'b0;
            if (ab) begin
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_sweep", sweep_cnt, nsw);
                chk("abort_cnt_en", cnt_en, 0);
                return;
            end
            if (h) held++;
            else   k++;
            if (k == len + 1) begin
                chk("end_busy", busy, 0);
                chk("end_done", done, 0);
                chk("end_sweep", sweep_cnt, n_v);
                return;
            end
        end
        chk("run_timeout", k, len + 1);
    endtask

    task automatic reject(input int lo_v, input int hi_v, input int n_v);
        start = 1'b1; lo = lo_v[3:0]; hi = hi_v[3:0]; n_sweeps = n_v[7:0];
        tick();
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_cnt_en", cnt_en, 0);
        tick();
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        int dt, a, b, nn, ha;
        reset = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        lo = '0; hi = '0; n_sweeps = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_cnt_up", cnt_up, 1);
        chk("rst_clr_n", cnt_clr_n, 1);
        chk("rst_sweep", sweep_cnt, 0);
        tick();
        reset = 1'b1;
        tick(); tick();

        do_run(2, 5, 1, -1, 0, -1, -1, dt);
        chk("t1_done_time", dt, 12 + 2 * TB_DWELL);

        reject(6, 3, 2);
        reject(1, 1, 0);

        do_run(0, 15, 3, -1, 0, -1, -1, dt);
        chk("t3_done_time", dt, 2 + 3 * (2 * 16 + 2 * TB_DWELL));

        do_run(2, 5, 1, 5, 5, -1, -1, dt);
        chk("hold_done_time", dt, 12 + 2 * TB_DWELL + 5);

        do_run(1, 6, 2, -1, 0, 11 + TB_DWELL, -1, dt);
        repeat (3) begin tick(); chk("post_abort_done", done, 0); chk("post_abort_busy", busy, 0); end

        do_run(3, 3, 2, -1, 0, -1, -1, dt);
        chk("lo_eq_hi_time", dt, 5 + 2 * (2 + 2 * TB_DWELL));

        do_run(3, 7, 2, -1, 0, -1, 6, dt);
        do_run(1, 4, 1, -1, 0, -1, -2, dt);
        do_run(2, 9, 1, -1, 0, -1, -1, dt);

        // reset while a run is in progress
        start = 1'b1; lo = 4'd0; hi = 4'd1; n_sweeps = 8'd3;
        tick();
        start = 1'b0;
        repeat (8) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt_en", cnt_en, 0);
        chk("mid_rst_cnt_up", cnt_up, 1);
        chk("mid_rst_clr_n", cnt_clr_n, 1);
        chk("mid_rst_sweep", sweep_cnt, 0);
        chk("mid_rst_count", count, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_done", done, 0);

        for (int r = 0; r < 8; r++) begin
            a  = int'($urandom_range(12, 0));
            b  = int'($urandom_range(15, a));
            nn = int'($urandom_range(3, 1));
            ha = ($urandom_range(1, 0) == 1) ? a + 2 : -1;
            do_run(a, b, nn, ha, int'($urandom_range(4, 1)), -1, -1, dt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
